// File: rtl/drfm_pkg.sv
// Shared widths, rounding constants and pipeline types for the DRFM Doppler path.
package drfm_pkg;

    localparam int SAMPLE_W = 16;
    localparam int NCO_W    = 17;
    localparam int PROD_W   = 33;
    localparam int SUM_W    = 34;

    localparam int SAT_MAX  = 32767;
    localparam int SAT_MIN  = -32768;
    localparam int ROUND_K  = 32768;
    localparam int SHIFT    = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [NCO_W-1:0]    nco_t;
    typedef logic signed [PROD_W-1:0]   prod_t;
    typedef logic signed [SUM_W-1:0]    sum_t;

    // Per-sample side information that travels alongside the arithmetic.
    typedef struct packed {
        logic    valid;
        logic    bypass;
        sample_t i;
        sample_t q;
    } tag_t;

endpackage

// File: rtl/doppler_mixer_if.sv
// Sample stream into and out of the Doppler mixer.
// Handshake: valid-only stream with no ready. A sample is transferred on every
// rising clock edge where in_valid (or out_valid) is high; the consumer must
// always accept it. Data is don't-care for transfer when its valid is low.
interface doppler_mixer_if;
    import drfm_pkg::*;

    logic    in_valid;
    sample_t in_i;
    sample_t in_q;
    nco_t    nco_cos;
    nco_t    nco_sin;
    logic    bypass;
    logic    out_valid;
    sample_t out_i;
    sample_t out_q;

    // Upstream side: drives samples and NCO, observes the shifted stream.
    modport master (
        output in_valid, in_i, in_q, nco_cos, nco_sin, bypass,
        input  out_valid, out_i, out_q
    );

    // Mixer side.
    modport slave (
        input  in_valid, in_i, in_q, nco_cos, nco_sin, bypass,
        output out_valid, out_i, out_q
    );

endinterface

// File: rtl/doppler_mixer_round_sat.sv
// Round half toward +inf, drop the 16 fraction bits, clamp to a 16-bit sample.
module round_sat
    import drfm_pkg::*;
(
    input  sum_t    sum,
    output sample_t res,
    output logic    sat
);

    sum_t biased;
    sum_t shifted;

    // Sums stay well inside 34 bits, so the rounding bias cannot overflow.
    assign biased  = sum + sum_t'(ROUND_K);
    assign shifted = biased >>> SHIFT;

    // Clamp the scaled value and flag when the clamp engaged.
    always_comb begin
        sat = 1'b0;
        res = shifted[SAMPLE_W-1:0];
        if (shifted > sum_t'(SAT_MAX)) begin
            res = sample_t'(SAT_MAX);
            sat = 1'b1;
        end else if (shifted < sum_t'(SAT_MIN)) begin
            res = sample_t'(SAT_MIN);
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/doppler_mixer.sv
// Complex frequency shift: (i + jq) * (cos + j sin), rounded and saturated to
// 16 bits, one sample per clock. Also offers a latency-matched bypass and a
// sticky saturation counter.
module doppler_mixer
    import drfm_pkg::*;
#(
    parameter int ALIGN_DLY = 1
) (
    input  logic            M100CLK,
    input  logic            reset_n,
    doppler_mixer_if.slave  bus,
    input  logic            sat_clr,
    output logic [15:0]     sat_count
);

    tag_t    in_tag;
    tag_t    d_tag;
    tag_t    p1_tag;
    tag_t    p2_tag;
    prod_t   p_ic;
    prod_t   p_qs;
    prod_t   p_is;
    prod_t   p_qc;
    sum_t    sum_i;
    sum_t    sum_q;
    sample_t rs_i;
    sample_t rs_q;
    logic    sat_i;
    logic    sat_q;
    logic    sat_evt;

    assign in_tag = '{valid: bus.in_valid, bypass: bus.bypass, i: bus.in_i, q: bus.in_q};

    // The NCO is not delayed: this line lines the sample up with the LUT output.
    generate
        if (ALIGN_DLY == 0) begin : g_no_dly
            assign d_tag = in_tag;
        end else begin : g_dly
            tag_t line [ALIGN_DLY];

            // Shift sample, valid and bypass together through the alignment line.
            always_ff @(posedge M100CLK or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < ALIGN_DLY; k++) line[k] <= '0;
                end else begin
                    line[0] <= in_tag;
                    for (int k = 1; k < ALIGN_DLY; k++) line[k] <= line[k-1];
                end
            end

            assign d_tag = line[ALIGN_DLY-1];
        end
    endgenerate

    // P1: the four cross products, NCO sampled as the sample leaves the line.
    always_ff @(posedge M100CLK or negedge reset_n) begin
        if (!reset_n) begin
            p_ic   <= '0;
            p_qs   <= '0;
            p_is   <= '0;
            p_qc   <= '0;
            p1_tag <= '0;
        end else begin
            p_ic   <= prod_t'($signed(d_tag.i)) * prod_t'(bus.nco_cos);
            p_qs   <= prod_t'($signed(d_tag.q)) * prod_t'(bus.nco_sin);
            p_is   <= prod_t'($signed(d_tag.i)) * prod_t'(bus.nco_sin);
            p_qc   <= prod_t'($signed(d_tag.q)) * prod_t'(bus.nco_cos);
            p1_tag <= d_tag;
        end
    end

    // P2: complex multiply sums.
    always_ff @(posedge M100CLK or negedge reset_n) begin
        if (!reset_n) begin
            sum_i  <= '0;
            sum_q  <= '0;
            p2_tag <= '0;
        end else begin
            sum_i  <= sum_t'(p_ic) - sum_t'(p_qs);
            sum_q  <= sum_t'(p_is) + sum_t'(p_qc);
            p2_tag <= p1_tag;
        end
    end

    round_sat u_round_i (.sum(sum_i), .res(rs_i), .sat(sat_i));
    round_sat u_round_q (.sum(sum_q), .res(rs_q), .sat(sat_q));

    // P3: select shifted or bypassed sample; hold outputs through invalid cycles.
    always_ff @(posedge M100CLK or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_i     <= '0;
            bus.out_q     <= '0;
            sat_evt       <= 1'b0;
        end else begin
            bus.out_valid <= p2_tag.valid;
            sat_evt       <= p2_tag.valid & ~p2_tag.bypass & (sat_i | sat_q);
            if (p2_tag.valid) begin
                bus.out_i <= p2_tag.bypass ? p2_tag.i : rs_i;
                bus.out_q <= p2_tag.bypass ? p2_tag.q : rs_q;
            end
        end
    end

    // Saturation events counted one cycle behind the output; clear has priority.
    always_ff @(posedge M100CLK or negedge reset_n) begin
        if (!reset_n) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (sat_evt && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_doppler_mixer.sv
// Bench for doppler_mixer: directed vectors, a per-cycle reference model built
// from recorded input history, and literal checks on hand-computed results.
module tb_doppler_mixer;

    localparam int AD  = 1;
    localparam int LAT = AD + 3;
    localparam int NC  = 75000;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_count;

    doppler_mixer_if bus ();

    doppler_mixer #(.ALIGN_DLY(AD)) dut (
        .M100CLK  (clk),
        .reset_n  (rst_n),
        .bus      (bus),
        .sat_clr  (sat_clr),
        .sat_count(sat_count)
    );

    // ---------------- clock / cycle index ----------------
    always #5 clk = ~clk;

    int cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters and check helper ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- input history (one entry per cycle) ----------------
    bit h_v   [NC];
    bit h_b   [NC];
    bit h_clr [NC];
    bit h_rst [NC];
    int h_i   [NC];
    int h_q   [NC];
    int h_c   [NC];
    int h_s   [NC];
    int h_lr  [NC];
    int last_low = -1;

    // Record what is being driven this cycle, then advance to the next cycle.
    task automatic tick();
        if (cyc >= NC) begin
            $display("FAIL history_overflow: got cycle %0d expected below %0d", cyc, NC);
            $fatal(1, "history exhausted");
        end
        h_v[cyc]   = bus.in_valid;
        h_b[cyc]   = bus.bypass;
        h_clr[cyc] = sat_clr;
        h_rst[cyc] = rst_n;
        h_i[cyc]   = bus.in_i;
        h_q[cyc]   = bus.in_q;
        h_c[cyc]   = bus.nco_cos;
        h_s[cyc]   = bus.nco_sin;
        if (!rst_n) last_low = cyc;
        h_lr[cyc]  = last_low;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference arithmetic ----------------
    // floor((x + 2^15) / 2^16), clamped to the 16-bit range.
    function automatic int scale(input longint x, output bit sat);
        longint t;
        longint r;
        t   = x + 64'sd32768;
        r   = t / 64'sd65536;
        if (t < 0 && (t % 64'sd65536) != 0) r = r - 1;
        sat = 1'b0;
        if (r > 32767) begin
            r = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            sat = 1'b1;
        end
        return int'(r);
    endfunction

    function automatic void mix(input int i, input int q, input int c, input int s,
                                output int oi, output int oq, output bit sat);
        longint re;
        longint im;
        bit     sa;
        bit     sb;
        re  = longint'(i) * c - longint'(q) * s;
        im  = longint'(i) * s + longint'(q) * c;
        oi  = scale(re, sa);
        oq  = scale(im, sb);
        sat = sa | sb;
    endfunction

    // ---------------- per-cycle model and compare ----------------
    bit m_v      = 1'b0;
    int m_i      = 0;
    int m_q      = 0;
    int m_cnt    = 0;
    bit prev_evt = 1'b0;

    always @(negedge clk) begin
        if (cyc >= 0) begin
            int n;
            int k;
            int oi;
            int oq;
            bit st;
            bit evt;
            n   = cyc;
            evt = 1'b0;
            if (!h_rst[n]) begin
                m_v   = 1'b0;
                m_i   = 0;
                m_q   = 0;
                m_cnt = 0;
            end else begin
                if (n > 0) begin
                    if (!h_rst[n-1] || h_clr[n-1]) m_cnt = 0;
                    else if (prev_evt && m_cnt != 65535) m_cnt = m_cnt + 1;
                end
                k   = n - LAT;
                m_v = 1'b0;
                if (k >= 0) begin
                    // Valid only if no reset touched the sample while in flight.
                    if (h_v[k] && h_lr[n-1] < k) m_v = 1'b1;
                end
                if (m_v) begin
                    if (h_b[k]) begin
                        m_i = h_i[k];
                        m_q = h_q[k];
                    end else begin
                        mix(h_i[k], h_q[k], h_c[k+AD], h_s[k+AD], oi, oq, st);
                        m_i = oi;
                        m_q = oq;
                        evt = st;
                    end
                end
            end
            prev_evt = evt;
            chk("out_valid", bus.out_valid, m_v);
            chk("out_i", bus.out_i, m_i);
            chk("out_q", bus.out_q, m_q);
            chk("sat_count", sat_count, m_cnt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_nco(input int c, input int s);
        bus.nco_cos = 17'(c);
        bus.nco_sin = 17'(s);
    endtask

    // One valid sample, then idle until its output is visible (cycle k+LAT).
    task automatic send(input int i, input int q, input bit byp);
        bus.in_valid = 1'b1;
        bus.in_i     = 16'(i);
        bus.in_q     = 16'(q);
        bus.bypass   = byp;
        tick();
        bus.in_valid = 1'b0;
        for (int j = 1; j < LAT; j++) begin
            chk("early_valid", bus.out_valid, 0);
            tick();
        end
        chk("lat_valid", bus.out_valid, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vseen;
        bus.in_valid = 1'b0;
        bus.in_i     = '0;
        bus.in_q     = '0;
        bus.bypass   = 1'b0;
        set_nco(0, 0);

        // Reset held while inputs toggle randomly: outputs must stay at zero.
        for (int j = 0; j < 8; j++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_i     = 16'($urandom);
            bus.in_q     = 16'($urandom);
            bus.bypass   = 1'($urandom_range(0, 1));
            sat_clr      = 1'($urandom_range(0, 1));
            set_nco(int'($urandom_range(0, 131071)) - 65536,
                    int'($urandom_range(0, 131071)) - 65536);
            tick();
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_i", bus.out_i, 0);
            chk("rst_sat_count", sat_count, 0);
        end
        rst_n        = 1'b1;
        sat_clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.bypass   = 1'b0;
        set_nco(65535, 0);
        tick();
        tick();

        // Zero shift, first sample after reset: latency is exactly LAT.
        send(1000, -2000, 1'b0);
        chk("zero_i", bus.out_i, 1000);
        chk("zero_q", bus.out_q, -2000);
        tick();
        chk("zero_sat", sat_count, 0);

        // 90 degree rotation.
        set_nco(0, 65535);
        send(1000, 500, 1'b0);
        chk("rot90_i", bus.out_i, -500);
        chk("rot90_q", bus.out_q, 1000);

        // Saturating Q, I rounds to zero; counter lands one cycle later.
        set_nco(46341, 46341);
        send(32767, 32767, 1'b0);
        chk("sat_i", bus.out_i, 0);
        chk("sat_q", bus.out_q, 32767);
        chk("sat_cnt_lag", sat_count, 0);
        tick();
        chk("sat_cnt_one", sat_count, 1);

        // Long saturating run: counter must stick at 0xFFFF.
        bus.in_valid = 1'b1;
        bus.in_i     = 16'sd32767;
        bus.in_q     = 16'sd32767;
        repeat (70000) tick();
        bus.in_valid = 1'b0;
        repeat (LAT) tick();
        chk("sat_sticky", sat_count, 16'hFFFF);

        // Plain clear, then clear racing a saturating output.
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("clr_plain", sat_count, 0);
        send(32767, 32767, 1'b0);
        chk("race_q", bus.out_q, 32767);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("clr_race", sat_count, 0);
        tick();
        chk("clr_race_after", sat_count, 0);

        // Bypass of a sample that would saturate: bit-exact, never counted.
        send(32767, 32767, 1'b1);
        chk("byp_i", bus.out_i, 32767);
        chk("byp_q", bus.out_q, 32767);
        set_nco(12345, -20000);
        send(-12345, 321, 1'b1);
        chk("byp2_i", bus.out_i, -12345);
        chk("byp2_q", bus.out_q, 321);
        tick();
        chk("byp_sat", sat_count, 0);

        // Alternating valid with bypass toggled mid-stream and a moving NCO.
        vseen = 0;
        for (int j = 0; j < 45; j++) begin
            bus.in_valid = (j < 40) && (j % 2 == 0);
            bus.bypass   = (j >= 10 && j < 25);
            bus.in_i     = 16'($urandom);
            bus.in_q     = 16'($urandom);
            set_nco(int'($urandom_range(0, 131071)) - 65536,
                    int'($urandom_range(0, 131071)) - 65536);
            tick();
            vseen += int'(bus.out_valid);
        end
        chk("gap_valid_count", vseen, 20);

        // Reset in the middle of a stream: nothing stale may emerge afterwards.
        set_nco(30000, -15000);
        bus.bypass   = 1'b0;
        bus.in_valid = 1'b1;
        repeat (6) begin
            bus.in_i = 16'($urandom);
            bus.in_q = 16'($urandom);
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", bus.out_valid, 0);
        tick();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        vseen = 0;
        repeat (8) begin
            tick();
            vseen += int'(bus.out_valid);
        end
        chk("midrst_stale", vseen, 0);

        // Pipeline works again after the mid-stream reset.
        set_nco(65535, 0);
        send(7, -7, 1'b0);
        chk("post_rst_i", bus.out_i, 7);
        chk("post_rst_q", bus.out_q, -7);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
